fan_duty_arbiter: RTL and testbench
===================================

# fan_duty_arbiter

Arbitrates fan duty requests from the manual, automatic (temperature) and remote control paths, and sequences the single shared `pwm_Nbit` motor driver. It owns the `duty` input of that driver: it grants one requester at a time, applies a kick-start pulse when the motor starts from standstill, and slews later duty changes at a bounded rate. It also provides an emergency stop. It sits between the mode modules (`local_auto` and its siblings) and the PWM instance.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency; sets the 1 ms tick divider (CLK_HZ/1000 cycles).
- `STEP_MS`, 4: ms between slew steps.
- `STEP_SIZE`, 5: maximum duty change per slew step (1..255).
- `KICK_DUTY`, 255: duty driven during kick-start.
- `KICK_MS`, 200: kick-start length in ms; 0 disables kick-start.

- `clk` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `req_valid` in 3: per-source request. Bit 0 manual, bit 1 auto, bit 2 remote.
- `req_duty` in 24: packed requested duty. [7:0] manual, [15:8] auto, [23:16] remote.
- `estop` in 1: emergency stop, level sensitive.
- `duty_out` out 8: registered duty to the PWM driver.
- `grant` out 3: registered one-hot current owner; all zero when there is no owner.
- `busy` out 1: high in S_KICK and S_RAMP.
- `kicking` out 1: high in S_KICK.

## Operation
- Reset values: `duty_out`=0, `grant`=0, `busy`=0, `kicking`=0, state S_OFF, ms/step/kick counters 0.
- **Arbitration (grant register, every cycle):**
  - If `req_valid[2]` is high, grant remote (pre-emptive).
  - Otherwise, if the current owner's valid bit is still high, keep the owner (locals are sticky toward each other).
  - Otherwise, grant by priority manual > auto; if no valid bit is high, `grant`=0.
- **Target:** `target` = `req_duty` slice of the owner, sampled live each cycle; 0 when `grant`=0.
- **States:**
  - S_OFF:
    - `duty_out`=0.
    - If target>0 and KICK_MS>0: go to S_KICK, `duty_out`<=KICK_DUTY, clear kick counter.
    - If target>0 and KICK_MS=0: go to S_HOLD, `duty_out`<=target.
  - S_KICK:
    - Count ms ticks.
    - If target becomes 0: go to S_OFF immediately, `duty_out`<=0.
    - On the KICK_MS-th tick: `duty_out`<=current target, go to S_HOLD. Target changes during the kick are absorbed this way.
  - S_HOLD:
    - If target≠`duty_out`: go to S_RAMP and clear the step counter.
  - S_RAMP:
    - On every STEP_MS-th ms tick after entry, move `duty_out` toward target by min(|target−duty_out|, STEP_SIZE).
    - Compute the difference in 9 bits; the result never wraps past 0 or 255.
    - When the new `duty_out` equals target: go to S_HOLD, or to S_OFF if target=0.
    - A target change mid-ramp only redirects the direction; the step counter is not restarted.
- **estop high:** asynchronous to FSM flow but synchronous to `clk`.
  - Next edge: `duty_out`<=0, state S_OFF, `grant`<=0, counters cleared.
  - Everything is held there while `estop`=1.
  - Normal arbitration resumes on the first cycle after `estop` falls. Restart from S_OFF includes a kick.
- **Simultaneous events:** estop > target=0 abort > kick expiry/step.
- **Owner switch:** a new owner with a different duty is treated as a target change. No kick is applied unless the state is S_OFF.

## Timing
- Grant updates 1 cycle after a `req_valid` change. `duty_out` reacts to the new target 1 cycle after that (S_OFF→S_KICK and S_HOLD→S_RAMP entry are registered).
- The 1 ms tick is free-running from reset and is not realigned. Step and kick counters count ticks from state entry, so the first step or kick end jitters by up to 1 ms.
- Full-scale slew time = ceil(255/STEP_SIZE)·STEP_MS ms (≈204 ms with defaults).
- Reset assertion mid-operation forces all outputs to their reset values immediately, with no clock required.

## Test plan
Use CLK_HZ=1000 (1 ms = 1 cycle), STEP_MS=2, STEP_SIZE=5, KICK_MS=3.
- **Reset:** `reset_n`=0 with `req_valid`=3'b111 → `duty_out`=0, `grant`=0, `busy`=0. After release, `grant`=3'b100 one cycle later.
- **Kick then hold:** `req_valid`=3'b001, manual=40 from S_OFF → `grant`=001; `duty_out`=255 with `kicking`=1 for 3 ticks; then `duty_out`=40, `busy`=0.
- **Slew:** in S_HOLD at 40, manual→57 → `duty_out` 45, 50, 55, 57, one step every 2 ticks, then S_HOLD. Manual→0 → ramps down by 5 to 0, then S_OFF.
- **Pre-emption and stickiness:** manual owns at 40; auto valid at 200 → grant stays 001. Remote valid at 100 → grant 100, ramp to 100. Remote drops → grant 001 (manual still valid), ramp back to 40.
- **Abort during kick:** start manual=40, drop `req_valid` during the kick → `duty_out`=0, S_OFF, `kicking`=0 on the next cycle.
- **Emergency stop:** at duty 150, pulse `estop` high for 5 cycles → `duty_out`=0 and `grant`=0 the next cycle, held for all 5 cycles; after release, a fresh kick (255 for 3 ticks) precedes 150.

Source files
------------

// File: rtl/fan_duty_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fan_duty_arbiter
// Purpose  : Arbitrates fan duty requests from the manual, auto and remote
//            control paths and sequences the shared PWM driver's duty input:
//            a kick-start pulse from standstill, rate-limited slewing
//            afterwards, and a level-sensitive emergency stop.
// Ports    : clk        - system clock, rising edge
//            reset_n    - asynchronous active-low reset
//            req_valid  - [0] manual, [1] auto, [2] remote request valid
//            req_duty   - [7:0] manual, [15:8] auto, [23:16] remote duty
//            estop      - emergency stop (level)
//            duty_out   - registered duty to the PWM driver
//            grant      - registered one-hot owner, zero when no owner
//            busy       - high while kicking or ramping
//            kicking    - high while kicking
// Revision : 1.0 - initial release
// ============================================================================
module fan_duty_arbiter #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int STEP_MS   = 4,
  parameter int STEP_SIZE = 5,
  parameter int KICK_DUTY = 255,
  parameter int KICK_MS   = 200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  req_valid,
  input  logic [23:0] req_duty,
  input  logic        estop,
  output logic [7:0]  duty_out,
  output logic [2:0]  grant,
  output logic        busy,
  output logic        kicking
);

  localparam int TICK_DIV  = (CLK_HZ / 1000 > 0) ? (CLK_HZ / 1000) : 1;
  localparam int MS_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int KICK_W    = (KICK_MS > 1) ? $clog2(KICK_MS + 1) : 1;
  localparam int STEP_W    = (STEP_MS > 1) ? $clog2(STEP_MS + 1) : 1;
  localparam int KICK_LAST = (KICK_MS > 0) ? (KICK_MS - 1) : 0;
  localparam int STEP_LAST = (STEP_MS > 0) ? (STEP_MS - 1) : 0;

  localparam logic [7:0] KICK_V = 8'(KICK_DUTY);
  localparam logic [8:0] STEP_V = 9'(STEP_SIZE);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_KICK = 2'd1,
    S_HOLD = 2'd2,
    S_RAMP = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [7:0]          duty_nx;
  logic [2:0]          grant_nx;
  logic [MS_W-1:0]     ms_cnt;
  logic                ms_tick;
  logic [KICK_W-1:0]   kick_cnt, kick_nx;
  logic [STEP_W-1:0]   step_cnt, step_nx;
  logic [7:0]          target;
  logic                ramp_up;
  logic [8:0]          ramp_mag;
  logic [8:0]          ramp_amt;
  logic [7:0]          ramp_next;

  // Free-running 1 ms tick; never realigned to state changes.
  assign ms_tick = (ms_cnt == MS_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms_cnt <= '0;
    end else if (ms_tick) begin
      ms_cnt <= '0;
    end else begin
      ms_cnt <= ms_cnt + 1'b1;
    end
  end

  // Remote pre-empts; otherwise the current owner is sticky while valid;
  // otherwise manual beats auto.
  always_comb begin
    grant_nx = 3'b000;
    if (estop) begin
      grant_nx = 3'b000;
    end else if (req_valid[2]) begin
      grant_nx = 3'b100;
    end else if (|(grant & req_valid)) begin
      grant_nx = grant;
    end else if (req_valid[0]) begin
      grant_nx = 3'b001;
    end else if (req_valid[1]) begin
      grant_nx = 3'b010;
    end
  end

  always_comb begin
    target = 8'd0;
    case (grant)
      3'b001:  target = req_duty[7:0];
      3'b010:  target = req_duty[15:8];
      3'b100:  target = req_duty[23:16];
      default: target = 8'd0;
    endcase
  end

  // Slew step: 9-bit magnitude, clamped to STEP_SIZE, so the result never
  // overshoots the target and never wraps.
  always_comb begin
    ramp_up  = (target >= duty_out);
    ramp_mag = ramp_up ? ({1'b0, target} - {1'b0, duty_out})
                       : ({1'b0, duty_out} - {1'b0, target});
    ramp_amt = (ramp_mag > STEP_V) ? STEP_V : ramp_mag;
    ramp_next = ramp_up ? (duty_out + ramp_amt[7:0])
                        : (duty_out - ramp_amt[7:0]);
  end

  always_comb begin
    state_nx = state;
    duty_nx  = duty_out;
    kick_nx  = kick_cnt;
    step_nx  = step_cnt;
    if (estop) begin
      state_nx = S_OFF;
      duty_nx  = 8'd0;
      kick_nx  = '0;
      step_nx  = '0;
    end else begin
      case (state)
        S_OFF: begin
          duty_nx = 8'd0;
          if (target != 8'd0) begin
            if (KICK_MS > 0) begin
              state_nx = S_KICK;
              duty_nx  = KICK_V;
              kick_nx  = '0;
            end else begin
              state_nx = S_HOLD;
              duty_nx  = target;
            end
          end
        end
        S_KICK: begin
          // Abort outranks kick expiry on the same cycle.
          if (target == 8'd0) begin
            state_nx = S_OFF;
            duty_nx  = 8'd0;
            kick_nx  = '0;
          end else if (ms_tick) begin
            if (kick_cnt == KICK_W'(KICK_LAST)) begin
              state_nx = S_HOLD;
              duty_nx  = target;
              kick_nx  = '0;
            end else begin
              kick_nx = kick_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (target != duty_out) begin
            state_nx = S_RAMP;
            step_nx  = '0;
          end
        end
        S_RAMP: begin
          // A target change mid-ramp only redirects the next step.
          if (ms_tick) begin
            if (step_cnt == STEP_W'(STEP_LAST)) begin
              step_nx = '0;
              duty_nx = ramp_next;
              if (ramp_next == target) begin
                state_nx = (target == 8'd0) ? S_OFF : S_HOLD;
              end
            end else begin
              step_nx = step_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nx = S_OFF;
          duty_nx  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_OFF;
      duty_out <= 8'd0;
      grant    <= 3'b000;
      kick_cnt <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_nx;
      duty_out <= duty_nx;
      grant    <= grant_nx;
      kick_cnt <= kick_nx;
      step_cnt <= step_nx;
    end
  end

  assign busy    = (state == S_KICK) || (state == S_RAMP);
  assign kicking = (state == S_KICK);

endmodule
`default_nettype wire

// File: tb/tb_fan_duty_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fan_duty_arbiter
// Purpose  : Directed self-checking bench for fan_duty_arbiter with a 1 ms
//            tick per clock, 2 ms slew steps of 5 and a 3 ms kick.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fan_duty_arbiter;

  logic        clk;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [23:0] req_duty;
  logic        estop;
  logic [7:0]  duty_out;
  logic [2:0]  grant;
  logic        busy;
  logic        kicking;

  int total_cnt = 0;
  int pass_cnt  = 0;

  fan_duty_arbiter #(
    .CLK_HZ    (1000),
    .STEP_MS   (2),
    .STEP_SIZE (5),
    .KICK_DUTY (255),
    .KICK_MS   (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_duty  (req_duty),
    .estop     (estop),
    .duty_out  (duty_out),
    .grant     (grant),
    .busy      (busy),
    .kicking   (kicking)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    total_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 3'b111;
    req_duty  = 24'd0;
    estop     = 1'b0;

    // Reset
    cyc(2);
    check("rst_duty", duty_out, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_kick", kicking, 0);
    reset_n = 1'b1;
    cyc(1);
    check("rel_grant_remote", grant, 3'b100);
    check("rel_duty_zero", duty_out, 0);
    req_valid = 3'b000;
    cyc(1);
    check("grant_none", grant, 0);

    // Kick then hold
    req_valid = 3'b001;
    req_duty  = 24'd40;
    cyc(1);
    check("kick_grant", grant, 3'b001);
    check("kick_pre_duty", duty_out, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("kick_duty", duty_out, 255);
      check("kick_flag", kicking, 1);
    end
    cyc(1);
    check("hold_duty", duty_out, 40);
    check("hold_busy", busy, 0);
    check("hold_kick", kicking, 0);

    // Slew up 40 -> 57
    req_duty = 24'd57;
    cyc(1);
    check("ramp_entry_duty", duty_out, 40);
    check("ramp_entry_busy", busy, 1);
    cyc(1);
    check("ramp_wait", duty_out, 40);
    cyc(1);
    check("ramp_45", duty_out, 45);
    cyc(2);
    check("ramp_50", duty_out, 50);
    cyc(2);
    check("ramp_55", duty_out, 55);
    cyc(1);
    check("ramp_between", duty_out, 55);
    cyc(1);
    check("ramp_57", duty_out, 57);
    check("ramp_done_busy", busy, 0);

    // Slew down 57 -> 0, ending in S_OFF without a kick
    req_duty = 24'd0;
    cyc(1);
    check("down_entry", duty_out, 57);
    cyc(2);
    check("down_52", duty_out, 52);
    for (int k = 1; k <= 10; k++) begin
      cyc(2);
      check("down_step", duty_out, 52 - 5 * k);
    end
    cyc(2);
    check("down_zero", duty_out, 0);
    check("down_busy", busy, 0);
    cyc(2);
    check("off_stays_zero", duty_out, 0);
    check("off_no_kick", kicking, 0);

    // Pre-emption and stickiness
    req_duty = 24'd40;
    cyc(1);
    check("pre_kick", duty_out, 255);
    cyc(3);
    check("pre_hold40", duty_out, 40);
    req_valid = 3'b011;
    req_duty  = {8'd0, 8'd200, 8'd40};
    cyc(1);
    check("sticky_grant", grant, 3'b001);
    cyc(2);
    check("sticky_grant2", grant, 3'b001);
    check("sticky_duty", duty_out, 40);
    req_valid = 3'b111;
    req_duty  = {8'd100, 8'd200, 8'd40};
    cyc(1);
    check("remote_grant", grant, 3'b100);
    cyc(1);
    check("remote_ramp_entry", duty_out, 40);
    for (int k = 1; k <= 12; k++) begin
      cyc(2);
      check("remote_up", duty_out, 40 + 5 * k);
    end
    check("remote_busy", busy, 0);
    req_valid = 3'b011;
    cyc(1);
    check("back_manual", grant, 3'b001);
    cyc(1);
    check("back_entry", duty_out, 100);
    for (int k = 1; k <= 12; k++) begin
      cyc(2);
      check("back_down", duty_out, 100 - 5 * k);
    end
    check("back_busy", busy, 0);

    // Return to standstill by ramping down
    req_valid = 3'b000;
    cyc(1);
    check("drop_grant", grant, 0);
    cyc(1);
    cyc(16);
    check("stop_duty", duty_out, 0);
    check("stop_busy", busy, 0);

    // Abort during kick
    req_valid = 3'b001;
    req_duty  = 24'd40;
    cyc(2);
    check("abort_kick_on", kicking, 1);
    req_valid = 3'b000;
    cyc(1);
    check("abort_grant", grant, 0);
    check("abort_still_kick", duty_out, 255);
    cyc(1);
    check("abort_duty", duty_out, 0);
    check("abort_kick_off", kicking, 0);
    check("abort_busy", busy, 0);

    // Emergency stop at 150
    req_valid = 3'b001;
    req_duty  = 24'd150;
    cyc(2);
    check("es_kick", duty_out, 255);
    cyc(3);
    check("es_hold150", duty_out, 150);
    estop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("es_duty", duty_out, 0);
      check("es_grant", grant, 0);
    end
    estop = 1'b0;
    cyc(1);
    check("es_regrant", grant, 3'b001);
    check("es_still_off", duty_out, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("es_rekick", duty_out, 255);
    end
    cyc(1);
    check("es_resume150", duty_out, 150);
    check("es_resume_busy", busy, 0);

    // Asynchronous reset mid-cycle, no clock edge needed
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_duty", duty_out, 0);
    check("async_grant", grant, 0);
    check("async_busy", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
